// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low hex keypad one column at a time,
// debounces a single key press, and reports it as a 4-bit hex code with a
// one-cycle valid strobe, a held flag and a display blanking flag.
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] data,
  output logic       valid,
  output logic       pressed,
  output logic       blank
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int MW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
  // match_reg never has to store DEBOUNCE itself: the sample that would
  // reach it takes the action directly.
  localparam logic [MW-1:0] MATCH_LAST = MW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    rs1_reg, rs_reg;
  logic [DW-1:0] div_reg, div_next;
  logic [1:0]    col_idx_reg, col_idx_next;
  logic [3:0]    col_reg, col_next;
  logic [MW-1:0] match_reg, match_next;
  logic [3:0]    cand_reg, cand_next;
  logic [3:0]    data_reg, data_next;
  logic          valid_reg, valid_next;
  logic          pressed_reg, pressed_next;
  logic          blank_reg, blank_next;

  logic       sample;
  logic       single;
  logic       advance;
  logic [3:0] low;
  logic [1:0] row_idx;
  logic [3:0] key;

  // Two-flop synchroniser for the asynchronous row inputs (idle level is high).
  always_ff @(posedge clk) begin
    if (reset) begin
      rs1_reg <= 4'b1111;
      rs_reg  <= 4'b1111;
    end else begin
      rs1_reg <= row;
      rs_reg  <= rs1_reg;
    end
  end

  assign low    = ~rs_reg;
  assign single = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
  assign sample = (div_reg == DIV_LAST);
  assign key    = {row_idx, col_idx_reg};

  // Position of the low row bit; only meaningful when exactly one bit is low.
  always_comb begin
    row_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (low[i]) row_idx = 2'(i);
    end
  end

  // One-hot-low column drive decoded from the next column index.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
      assign col_next[gi] = (col_idx_next != 2'(gi));
    end
  endgenerate

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_SCAN;
      div_reg     <= '0;
      col_idx_reg <= 2'd0;
      col_reg     <= 4'b1110;
      match_reg   <= '0;
      cand_reg    <= 4'd0;
      data_reg    <= 4'd0;
      valid_reg   <= 1'b0;
      pressed_reg <= 1'b0;
      blank_reg   <= 1'b1;
    end else begin
      state_reg   <= state_next;
      div_reg     <= div_next;
      col_idx_reg <= col_idx_next;
      col_reg     <= col_next;
      match_reg   <= match_next;
      cand_reg    <= cand_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      pressed_reg <= pressed_next;
      blank_reg   <= blank_next;
    end
  end

  // Next-state logic: every decision is taken only on a sample event.
  always_comb begin
    state_next   = state_reg;
    div_next     = sample ? '0 : div_reg + DW'(1);
    match_next   = match_reg;
    cand_next    = cand_reg;
    data_next    = data_reg;
    valid_next   = 1'b0;
    pressed_next = pressed_reg;
    blank_next   = blank_reg;
    advance      = 1'b0;

    if (sample) begin
      unique case (state_reg)
        ST_SCAN: begin
          if (single) begin
            cand_next = key;
            if (MATCH_LAST == '0) begin
              // One matching sample is enough: accept straight away.
              data_next    = key;
              valid_next   = 1'b1;
              pressed_next = 1'b1;
              blank_next   = 1'b0;
              match_next   = '0;
              state_next   = ST_HELD;
            end else begin
              match_next = MW'(1);
              state_next = ST_DEBOUNCE;
            end
          end else begin
            advance = 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (single && (key == cand_reg)) begin
            if (match_reg == MATCH_LAST) begin
              data_next    = cand_reg;
              valid_next   = 1'b1;
              pressed_next = 1'b1;
              blank_next   = 1'b0;
              match_next   = '0;
              state_next   = ST_HELD;
            end else begin
              match_next = match_reg + MW'(1);
            end
          end else begin
            // Bounce or a different pattern: abandon the candidate silently.
            match_next = '0;
            state_next = ST_SCAN;
            advance    = 1'b1;
          end
        end
        ST_HELD: begin
          if (rs_reg == 4'b1111) begin
            if (match_reg == MATCH_LAST) begin
              pressed_next = 1'b0;
              match_next   = '0;
              state_next   = ST_SCAN;
              advance      = 1'b1;
            end else begin
              match_next = match_reg + MW'(1);
            end
          end else begin
            // Any low row (same key or others) restarts the release count.
            match_next = '0;
          end
        end
        default: begin
          match_next = '0;
          state_next = ST_SCAN;
        end
      endcase
    end

    col_idx_next = advance ? col_idx_reg + 2'd1 : col_idx_reg;
  end

  assign col     = col_reg;
  assign data    = data_reg;
  assign valid   = valid_reg;
  assign pressed = pressed_reg;
  assign blank   = blank_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a simulated 4x4 keypad matrix from the scanner's
// column outputs and checks every cycle against a behavioural model.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  data;
  logic        valid;
  logic        pressed;
  logic        blank;
  logic [15:0] keys;

  int errors    = 0;
  int checks    = 0;
  int valid_cnt = 0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col),
    .data(data), .valid(valid), .pressed(pressed), .blank(blank)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  // ---------------- behavioural model ----------------
  typedef enum {M_SCAN, M_CONF, M_HOLD} mphase_t;
  mphase_t    m_ph;
  logic [3:0] s1, s2;
  int         t_div, m_col, m_cnt, m_cand;
  logic [3:0] m_data;
  logic       m_valid, m_pressed, m_blank;

  task automatic model_reset();
    s1 = 4'hF; s2 = 4'hF;
    t_div = 0; m_col = 0; m_ph = M_SCAN; m_cnt = 0; m_cand = 0;
    m_data = 4'h0; m_valid = 1'b0; m_pressed = 1'b0; m_blank = 1'b1;
  endtask

  task automatic model_accept();
    m_data = 4'(m_cand); m_valid = 1'b1; m_pressed = 1'b1; m_blank = 1'b0;
    m_ph = M_HOLD; m_cnt = 0;
  endtask

  task automatic model_step(input bit rst, input logic [3:0] rin);
    logic [3:0] seen;
    logic [3:0] lowbits;
    int lows, r, code;
    bit smp, adv;
    if (rst) begin
      model_reset();
      return;
    end
    seen = s2; s2 = s1; s1 = rin;
    m_valid = 1'b0;
    smp = (t_div == SD - 1);
    t_div = smp ? 0 : t_div + 1;
    adv = 1'b0;
    if (smp) begin
      lowbits = ~seen;
      lows = $countones(lowbits);
      r = 0;
      for (int i = 0; i < 4; i++) if (lowbits[i]) r = i;
      code = r * 4 + m_col;
      case (m_ph)
        M_SCAN: begin
          if (lows == 1) begin
            m_cand = code; m_cnt = 1; m_ph = M_CONF;
            if (m_cnt == DB) model_accept();
          end else adv = 1'b1;
        end
        M_CONF: begin
          if (lows == 1 && code == m_cand) begin
            m_cnt++;
            if (m_cnt == DB) model_accept();
          end else begin
            m_ph = M_SCAN; m_cnt = 0; adv = 1'b1;
          end
        end
        default: begin
          if (seen == 4'hF) begin
            m_cnt++;
            if (m_cnt == DB) begin
              m_pressed = 1'b0; m_ph = M_SCAN; m_cnt = 0; adv = 1'b1;
            end
          end else m_cnt = 0;
        end
      endcase
    end
    if (adv) m_col = (m_col + 1) % 4;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: capture inputs, advance DUT and model, compare all outputs.
  task automatic tick();
    logic [3:0] row_pre;
    logic       rst_pre;
    logic [3:0] exp_col;
    #1;
    row_pre = row;
    rst_pre = reset;
    @(posedge clk);
    #1;
    model_step(rst_pre, row_pre);
    exp_col = 4'hF ^ (4'h1 << m_col);
    check("col", {4'h0, col}, {4'h0, exp_col});
    check("data", {4'h0, data}, {4'h0, m_data});
    check("valid", {7'h0, valid}, {7'h0, m_valid});
    check("pressed", {7'h0, pressed}, {7'h0, m_pressed});
    check("blank", {7'h0, blank}, {7'h0, m_blank});
    if (valid === 1'b1) valid_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_conf2(input string name);
    bit reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      tick();
      if (m_ph == M_CONF && m_cnt == 2) reached = 1'b1;
    end
    check(name, {7'h0, reached}, 8'h01);
  endtask

  initial begin
    reset = 1'b1;
    keys  = 16'h0;
    model_reset();

    // Reset state
    run(3);
    check("rst_col", {4'h0, col}, 8'h0E);
    check("rst_data", {4'h0, data}, 8'h00);
    check("rst_valid", {7'h0, valid}, 8'h00);
    check("rst_pressed", {7'h0, pressed}, 8'h00);
    check("rst_blank", {7'h0, blank}, 8'h01);

    // Idle column rotation: column 1 appears on the SCAN_DIV-th edge
    reset = 1'b0;
    run(3);
    check("idle_col0", {4'h0, col}, 8'h0E);
    tick();
    check("idle_col1", {4'h0, col}, 8'h0D);
    run(SD);
    check("idle_col2", {4'h0, col}, 8'h0B);
    run(20);
    check("idle_no_valid", 8'(valid_cnt), 8'h00);

    // Key row 2 / col 1 -> code 9
    keys[9] = 1'b1;
    run(60);
    check("k9_valid_cnt", 8'(valid_cnt), 8'h01);
    check("k9_data", {4'h0, data}, 8'h09);
    check("k9_pressed", {7'h0, pressed}, 8'h01);
    check("k9_blank", {7'h0, blank}, 8'h00);
    check("k9_col_held", {4'h0, col}, 8'h0D);
    keys = 16'h0;
    run(30);
    check("k9_released", {7'h0, pressed}, 8'h00);
    check("k9_data_kept", {4'h0, data}, 8'h09);

    // Bounce on key row 3 / col 3: released just before the accepting sample
    valid_cnt = 0;
    keys[15] = 1'b1;
    wait_conf2("bounce_reach");
    keys = 16'h0;
    run(20);
    check("bounce_no_valid", 8'(valid_cnt), 8'h00);
    keys[15] = 1'b1;
    run(80);
    check("bounce_data", {4'h0, data}, 8'h0F);
    check("bounce_valid_cnt", 8'(valid_cnt), 8'h01);
    keys = 16'h0;
    run(40);

    // Two keys in the same column (rows 0 and 1, col 0)
    valid_cnt = 0;
    keys[0] = 1'b1; keys[4] = 1'b1;
    run(80);
    check("samecol_no_valid", 8'(valid_cnt), 8'h00);
    keys = 16'h0;
    run(20);

    // Keys in cols 0 and 2 pressed while col 3 is scanned: col 0 wins
    valid_cnt = 0;
    begin
      bit at3 = 1'b0;
      for (int i = 0; i < 100 && !at3; i++) begin
        tick();
        if (m_col == 3 && m_ph == M_SCAN) at3 = 1'b1;
      end
      check("twocol_reach", {7'h0, at3}, 8'h01);
    end
    keys[0] = 1'b1; keys[2] = 1'b1;
    run(80);
    check("twocol_data", {4'h0, data}, 8'h00);
    check("twocol_valid_cnt", 8'(valid_cnt), 8'h01);
    keys[0] = 1'b0;
    run(80);
    check("twocol_second", {4'h0, data}, 8'h02);
    check("twocol_valid_cnt2", 8'(valid_cnt), 8'h02);
    keys = 16'h0;
    run(40);

    // Reset while debouncing key 5 with two matches already seen
    keys[5] = 1'b1;
    wait_conf2("rstdeb_reach");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstdeb_col", {4'h0, col}, 8'h0E);
    check("rstdeb_valid", {7'h0, valid}, 8'h00);
    check("rstdeb_pressed", {7'h0, pressed}, 8'h00);
    check("rstdeb_blank", {7'h0, blank}, 8'h01);
    check("rstdeb_data", {4'h0, data}, 8'h00);
    valid_cnt = 0;
    run(80);
    check("rstdeb_repress", {4'h0, data}, 8'h05);
    check("rstdeb_valid_cnt", 8'(valid_cnt), 8'h01);
    keys = 16'h0;
    run(40);

    // Held key 6 while key 14 (same column) chatters
    valid_cnt = 0;
    keys[6] = 1'b1;
    run(60);
    check("chat_data", {4'h0, data}, 8'h06);
    for (int i = 0; i < 40; i++) begin
      keys[14] = 1'($urandom_range(0, 1));
      tick();
    end
    check("chat_valid_cnt", 8'(valid_cnt), 8'h01);
    check("chat_pressed", {7'h0, pressed}, 8'h01);
    keys = 16'h0;
    run(40);
    check("chat_released", {7'h0, pressed}, 8'h00);

    // Randomised presses, checked cycle by cycle against the model
    for (int it = 0; it < 25; it++) begin
      keys = 16'h0;
      keys[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] = 1'b1;
      run($urandom_range(3, 60));
      keys = 16'h0;
      run($urandom_range(3, 40));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
